// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: CP0 register indices, sideband bit
// positions and the control half of a buffered pipeline entry.
package mem_wb_pkg;

    localparam int CP0_EPC      = 14;
    localparam int CP0_STATUS   = 12;
    localparam int CP0_CAUSE    = 13;
    localparam int CP0_BADVADDR = 8;

    localparam logic [31:0] CP0_IMPL_MASK_DEFAULT = 32'h000C_FD0D;

    // Bit positions inside the {badaddr,cause,status,epc} sideband enable
    localparam int SB_EPC     = 0;
    localparam int SB_STATUS  = 1;
    localparam int SB_CAUSE   = 2;
    localparam int SB_BADADDR = 3;

    typedef struct packed {
        logic [4:0] wrAddr;
        logic       wrReg;
        logic       wrHi;
        logic       wrLo;
        logic       cpWe;
        logic [4:0] cpAddr;
        logic [3:0] excWe;
    } wbEntryCtrl_t;

    // A flushed entry loses its architectural writes but keeps its sideband
    function automatic wbEntryCtrl_t killWrites(input wbEntryCtrl_t e);
        killWrites       = e;
        killWrites.wrReg = 1'b0;
        killWrites.wrHi  = 1'b0;
        killWrites.wrLo  = 1'b0;
        killWrites.cpWe  = 1'b0;
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// MEM -> WB handshake bundle: incoming MEM entry, WB head-entry fields and the
// decoded CP0 write port.
interface mem_wb_if #(
    parameter int DW     = 32,
    parameter int NUM_CP = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [4:0]        in_wr_addr;
    logic              in_wr_reg;
    logic [DW-1:0]     in_wr_data;
    logic [DW-1:0]     in_hi;
    logic [DW-1:0]     in_lo;
    logic              in_wr_hi;
    logic              in_wr_lo;
    logic              in_cp_we;
    logic [4:0]        in_cp_addr;
    logic [DW-1:0]     in_cp_data;
    logic [3:0]        in_exc_we;
    logic [4*DW-1:0]   in_exc_data;

    logic              out_valid;
    logic              out_ready;
    logic [4:0]        wb_wr_addr;
    logic              wb_wr_reg;
    logic [DW-1:0]     wb_wr_data;
    logic [DW-1:0]     wb_hi;
    logic [DW-1:0]     wb_lo;
    logic              wb_wr_hi;
    logic              wb_wr_lo;
    logic [NUM_CP-1:0]    cp_we_vec;
    logic [NUM_CP*DW-1:0] cp_wdata;
    logic [15:0]       cp_conflict_cnt;
    logic              cp_drop;

    modport master (
        output in_valid, flush, in_wr_addr, in_wr_reg, in_wr_data, in_hi, in_lo,
               in_wr_hi, in_wr_lo, in_cp_we, in_cp_addr, in_cp_data, in_exc_we,
               in_exc_data, out_ready,
        input  in_ready, out_valid, wb_wr_addr, wb_wr_reg, wb_wr_data, wb_hi, wb_lo,
               wb_wr_hi, wb_wr_lo, cp_we_vec, cp_wdata, cp_conflict_cnt, cp_drop
    );

    modport slave (
        input  in_valid, flush, in_wr_addr, in_wr_reg, in_wr_data, in_hi, in_lo,
               in_wr_hi, in_wr_lo, in_cp_we, in_cp_addr, in_cp_data, in_exc_we,
               in_exc_data, out_ready,
        output in_ready, out_valid, wb_wr_addr, wb_wr_reg, wb_wr_data, wb_hi, wb_lo,
               wb_wr_hi, wb_wr_lo, cp_we_vec, cp_wdata, cp_conflict_cnt, cp_drop
    );
endinterface

// File: rtl/mem_wb_stage_cp0_write_decode.sv
// Turns the committing head entry into per-register CP0 write strobes; the
// exception sideband always beats an mtc0 aimed at the same register.
module cp0_write_decode
    import mem_wb_pkg::*;
#(
    parameter int          DW           = 32,
    parameter int          NUM_CP       = 32,
    parameter logic [31:0] CP_IMPL_MASK = CP0_IMPL_MASK_DEFAULT,
    parameter int          EPC_IDX      = CP0_EPC,
    parameter int          STATUS_IDX   = CP0_STATUS,
    parameter int          CAUSE_IDX    = CP0_CAUSE,
    parameter int          BADADDR_IDX  = CP0_BADVADDR
) (
    input  logic                 commit_i,
    input  logic                 cpWe_i,
    input  logic [4:0]           cpAddr_i,
    input  logic [DW-1:0]        cpData_i,
    input  logic [3:0]           excWe_i,
    input  logic [4*DW-1:0]      excData_i,
    output logic [NUM_CP-1:0]    weVec_o,
    output logic [NUM_CP*DW-1:0] wdata_o,
    output logic                 conflict_o,
    output logic                 drop_o
);

    logic implemented;
    logic sbHit;

    function automatic int sbSlot(input int k);
        case (k)
            SB_EPC:    sbSlot = EPC_IDX;
            SB_STATUS: sbSlot = STATUS_IDX;
            SB_CAUSE:  sbSlot = CAUSE_IDX;
            default:   sbSlot = BADADDR_IDX;
        endcase
    endfunction

    always_comb begin
        weVec_o     = '0;
        wdata_o     = '0;
        conflict_o  = 1'b0;
        drop_o      = 1'b0;
        sbHit       = 1'b0;
        implemented = (int'(cpAddr_i) < NUM_CP) && CP_IMPL_MASK[cpAddr_i];
        for (int k = 0; k < 4; k++) begin
            if (excWe_i[k] && (sbSlot(k) == int'(cpAddr_i))) sbHit = 1'b1;
        end
        if (commit_i) begin
            if (cpWe_i) begin
                if (!implemented) begin
                    drop_o = 1'b1;
                end else if (sbHit) begin
                    conflict_o = 1'b1;
                end else begin
                    weVec_o[cpAddr_i]                 = 1'b1;
                    wdata_o[int'(cpAddr_i)*DW +: DW] = cpData_i;
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (excWe_i[k]) begin
                    weVec_o[sbSlot(k)]           = 1'b1;
                    wdata_o[sbSlot(k)*DW +: DW] = excData_i[k*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register built as a 2-entry skid FIFO; commits GPR, HI/LO
// and CP0 writes only on the WB pop handshake.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int          DW           = 32,
    parameter int          NUM_CP       = 32,
    parameter logic [31:0] CP_IMPL_MASK = CP0_IMPL_MASK_DEFAULT,
    parameter int          EPC_IDX      = CP0_EPC,
    parameter int          STATUS_IDX   = CP0_STATUS,
    parameter int          CAUSE_IDX    = CP0_CAUSE,
    parameter int          BADADDR_IDX  = CP0_BADVADDR,
    parameter logic [15:0] CNT_RESET    = 16'h0000
) (
    input logic     clock,
    input logic     reset,
    mem_wb_if.slave bus
);

    wbEntryCtrl_t    ctrl_q    [2];
    logic [DW-1:0]   wrData_q  [2];
    logic [DW-1:0]   hi_q      [2];
    logic [DW-1:0]   lo_q      [2];
    logic [DW-1:0]   cpData_q  [2];
    logic [4*DW-1:0] excData_q [2];

    logic        head_q, head_d, tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] cnt_q, cnt_d;
    logic        push, pop, outValid, conflict;
    wbEntryCtrl_t inCtrl, headCtrl;

    always_comb begin
        outValid      = (count_q != 2'd0);
        push          = bus.in_valid && (count_q != 2'd2);
        pop           = outValid && bus.out_ready;
        inCtrl.wrAddr = bus.in_wr_addr;
        inCtrl.wrReg  = bus.in_wr_reg;
        inCtrl.wrHi   = bus.in_wr_hi;
        inCtrl.wrLo   = bus.in_wr_lo;
        inCtrl.cpWe   = bus.in_cp_we;
        inCtrl.cpAddr = bus.in_cp_addr;
        inCtrl.excWe  = bus.in_exc_we;
        if (bus.flush) inCtrl = killWrites(inCtrl);
        // A head popped during a flush cycle is a held entry too, so it loses its writes now
        headCtrl = ctrl_q[head_q];
        if (bus.flush) headCtrl = killWrites(headCtrl);
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        cnt_d = cnt_q;
        if (conflict && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                ctrl_q[i]    <= '0;
                wrData_q[i]  <= '0;
                hi_q[i]      <= '0;
                lo_q[i]      <= '0;
                cpData_q[i]  <= '0;
                excData_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.flush) ctrl_q[i] <= killWrites(ctrl_q[i]);
            end
            if (push) begin
                ctrl_q[tail_q]    <= inCtrl;
                wrData_q[tail_q]  <= bus.in_wr_data;
                hi_q[tail_q]      <= bus.in_hi;
                lo_q[tail_q]      <= bus.in_lo;
                cpData_q[tail_q]  <= bus.in_cp_data;
                excData_q[tail_q] <= bus.in_exc_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            cnt_q   <= CNT_RESET;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.in_ready        = (count_q != 2'd2);
        bus.out_valid       = outValid;
        bus.wb_wr_addr      = outValid ? headCtrl.wrAddr   : '0;
        bus.wb_wr_data      = outValid ? wrData_q[head_q]  : '0;
        bus.wb_hi           = outValid ? hi_q[head_q]      : '0;
        bus.wb_lo           = outValid ? lo_q[head_q]      : '0;
        bus.wb_wr_reg       = headCtrl.wrReg & pop;
        bus.wb_wr_hi        = headCtrl.wrHi & pop;
        bus.wb_wr_lo        = headCtrl.wrLo & pop;
        bus.cp_conflict_cnt = cnt_q;
    end

    cp0_write_decode #(
        .DW           (DW),
        .NUM_CP       (NUM_CP),
        .CP_IMPL_MASK (CP_IMPL_MASK),
        .EPC_IDX      (EPC_IDX),
        .STATUS_IDX   (STATUS_IDX),
        .CAUSE_IDX    (CAUSE_IDX),
        .BADADDR_IDX  (BADADDR_IDX)
    ) u_decode (
        .commit_i   (pop),
        .cpWe_i     (headCtrl.cpWe),
        .cpAddr_i   (headCtrl.cpAddr),
        .cpData_i   (cpData_q[head_q]),
        .excWe_i    (headCtrl.excWe),
        .excData_i  (excData_q[head_q]),
        .weVec_o    (bus.cp_we_vec),
        .wdata_o    (bus.cp_wdata),
        .conflict_o (conflict),
        .drop_o     (bus.cp_drop)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them on every WB handshake.
module tb_mem_wb_stage;
    import mem_wb_pkg::*;

    localparam int DW     = 32;
    localparam int NUM_CP = 32;

    typedef struct packed {
        logic [4:0]   wrAddr;
        logic         wrReg;
        logic [31:0]  wrData;
        logic [31:0]  hi;
        logic [31:0]  lo;
        logic         wrHi;
        logic         wrLo;
        logic         cpWe;
        logic [4:0]   cpAddr;
        logic [31:0]  cpData;
        logic [3:0]   excWe;
        logic [127:0] excData;
    } stim_t;

    typedef struct packed {
        logic [4:0]    wrAddr;
        logic          wrReg;
        logic [31:0]   wrData;
        logic [31:0]   hi;
        logic [31:0]   lo;
        logic          wrHi;
        logic          wrLo;
        logic [31:0]   weVec;
        logic [1023:0] wdata;
        logic          drop;
        logic [15:0]   cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_wb_if #(.DW(DW), .NUM_CP(NUM_CP)) bus ();
    mem_wb_if #(.DW(DW), .NUM_CP(NUM_CP)) bus2 ();

    mem_wb_stage #(.DW(DW), .NUM_CP(NUM_CP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    mem_wb_stage #(.DW(DW), .NUM_CP(NUM_CP), .CNT_RESET(16'hFFFF)) dutSat (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    exp_t        expQ[$];
    exp_t        monE;
    int          compared   = 0;
    int          mismatched = 0;
    logic        cntPending = 1'b0;
    logic [15:0] cntWant;
    stim_t       s;
    exp_t        e;

    task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [1023:0] slot(input int idx, input logic [31:0] v);
        slot = '0;
        slot[idx*32 +: 32] = v;
    endfunction

    function automatic stim_t gprStim(input logic [4:0] a, input logic [31:0] d);
        gprStim        = '0;
        gprStim.wrAddr = a;
        gprStim.wrReg  = 1'b1;
        gprStim.wrData = d;
    endfunction

    function automatic exp_t gprExp(input logic [4:0] a, input logic [31:0] d, input logic [15:0] c);
        gprExp        = '0;
        gprExp.wrAddr = a;
        gprExp.wrReg  = 1'b1;
        gprExp.wrData = d;
        gprExp.cnt    = c;
    endfunction

    task automatic driveIdle();
        bus.in_valid = 1'b0;  bus.flush = 1'b0;  bus.out_ready = 1'b0;
        bus.in_wr_addr = '0;  bus.in_wr_reg = 1'b0;  bus.in_wr_data = '0;
        bus.in_hi = '0;  bus.in_lo = '0;  bus.in_wr_hi = 1'b0;  bus.in_wr_lo = 1'b0;
        bus.in_cp_we = 1'b0;  bus.in_cp_addr = '0;  bus.in_cp_data = '0;
        bus.in_exc_we = '0;  bus.in_exc_data = '0;
        bus2.in_valid = 1'b0;  bus2.flush = 1'b0;  bus2.out_ready = 1'b0;
        bus2.in_wr_addr = '0;  bus2.in_wr_reg = 1'b0;  bus2.in_wr_data = '0;
        bus2.in_hi = '0;  bus2.in_lo = '0;  bus2.in_wr_hi = 1'b0;  bus2.in_wr_lo = 1'b0;
        bus2.in_cp_we = 1'b0;  bus2.in_cp_addr = '0;  bus2.in_cp_data = '0;
        bus2.in_exc_we = '0;  bus2.in_exc_data = '0;
    endtask

    // Offer one MEM entry, wait (bounded) for in_ready, then complete the push
    task automatic applyStimulus(input stim_t st, input exp_t ex);
        int waited;
        bus.in_wr_addr = st.wrAddr;  bus.in_wr_reg = st.wrReg;  bus.in_wr_data = st.wrData;
        bus.in_hi = st.hi;  bus.in_lo = st.lo;  bus.in_wr_hi = st.wrHi;  bus.in_wr_lo = st.wrLo;
        bus.in_cp_we = st.cpWe;  bus.in_cp_addr = st.cpAddr;  bus.in_cp_data = st.cpData;
        bus.in_exc_we = st.excWe;  bus.in_exc_data = st.excData;
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 40) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL push_timeout: in_ready stayed %0b, required 1", bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            expQ.push_back(ex);
            @(posedge clock); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Monitor: compare the head on each pop, the counter one cycle later, and quiet outputs when idle
    initial begin
        forever begin
            @(negedge clock);
            if (cntPending) begin
                checkOutput("conflict_cnt", bus.cp_conflict_cnt, cntWant);
                cntPending = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_pop: got data %0h with empty scoreboard", bus.wb_wr_data);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("wb_wr_addr", bus.wb_wr_addr, monE.wrAddr);
                    checkOutput("wb_wr_reg",  bus.wb_wr_reg,  monE.wrReg);
                    checkOutput("wb_wr_data", bus.wb_wr_data, monE.wrData);
                    checkOutput("wb_hilo",    {bus.wb_hi, bus.wb_lo, bus.wb_wr_hi, bus.wb_wr_lo},
                                              {monE.hi, monE.lo, monE.wrHi, monE.wrLo});
                    checkOutput("cp_we_vec",  bus.cp_we_vec, monE.weVec);
                    checkOutput("cp_wdata",   bus.cp_wdata,  monE.wdata);
                    checkOutput("cp_drop",    bus.cp_drop,   monE.drop);
                    cntWant    = monE.cnt;
                    cntPending = 1'b1;
                end
            end else if (!bus.out_valid) begin
                checkOutput("idle_zero", {bus.wb_wr_reg, bus.wb_wr_hi, bus.wb_wr_lo, bus.wb_wr_addr,
                                          bus.wb_wr_data, bus.wb_hi, bus.wb_lo, bus.cp_we_vec,
                                          bus.cp_drop, bus.cp_wdata}, '0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d entries outstanding", expQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        driveIdle();
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("reset_in_ready",  bus.in_ready, 1'b1);
        checkOutput("reset_out_valid", bus.out_valid, 1'b0);
        checkOutput("reset_cnt",       bus.cp_conflict_cnt, 16'h0000);
        checkOutput("reset_we_vec",    bus.cp_we_vec, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        $display("[TB] single GPR write, latency 1");
        bus.out_ready = 1'b1;
        applyStimulus(gprStim(5'd5, 32'h1234_5678), gprExp(5'd5, 32'h1234_5678, 16'd0));
        checkOutput("latency_out_valid", bus.out_valid, 1'b1);
        @(posedge clock); #1;
        checkOutput("drained_out_valid", bus.out_valid, 1'b0);

        $display("[TB] backpressure with three entries");
        bus.out_ready = 1'b0;
        applyStimulus(gprStim(5'd1, 32'hAAAA_0001), gprExp(5'd1, 32'hAAAA_0001, 16'd0));
        checkOutput("one_held_in_ready", bus.in_ready, 1'b1);
        applyStimulus(gprStim(5'd2, 32'hBBBB_0002), gprExp(5'd2, 32'hBBBB_0002, 16'd0));
        checkOutput("full_in_ready", bus.in_ready, 1'b0);
        fork
            applyStimulus(gprStim(5'd3, 32'hCCCC_0003), gprExp(5'd3, 32'hCCCC_0003, 16'd0));
            begin
                repeat (2) @(posedge clock);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] mtc0 decode and drop");
        s = '0;  s.cpWe = 1'b1;  s.cpAddr = 5'd12;  s.cpData = 32'h0000_FF01;
        e = '0;  e.weVec = 32'h1 << 12;  e.wdata = slot(12, 32'h0000_FF01);
        applyStimulus(s, e);
        s = '0;  s.cpWe = 1'b1;  s.cpAddr = 5'd1;  s.cpData = 32'h1111_1111;
        e = '0;  e.drop = 1'b1;
        applyStimulus(s, e);

        $display("[TB] mtc0 collides with EPC sideband");
        s = '0;  s.cpWe = 1'b1;  s.cpAddr = 5'd14;  s.cpData = 32'hAAAA_AAAA;
        s.excWe = 4'b0001;  s.excData = {96'h0, 32'hBFC0_0380};
        e = '0;  e.weVec = 32'h1 << 14;  e.wdata = slot(14, 32'hBFC0_0380);  e.cnt = 16'd1;
        applyStimulus(s, e);
        repeat (2) @(posedge clock);
        #1;

        $display("[TB] flush of held and incoming entries");
        bus.out_ready = 1'b0;
        e = gprExp(5'd3, 32'h0000_0033, 16'd1);
        e.wrReg = 1'b0;
        applyStimulus(gprStim(5'd3, 32'h0000_0033), e);
        s = gprStim(5'd4, 32'h0000_0044);
        s.wrHi = 1'b1;  s.hi = 32'h0000_4411;  s.cpWe = 1'b1;  s.cpAddr = 5'd10;
        s.excWe = 4'b0111;
        s.excData = {32'h0, 32'h0000_0010, 32'h0000_FF03, 32'h1000_0004};
        e = gprExp(5'd4, 32'h0000_0044, 16'd1);
        e.wrReg = 1'b0;  e.hi = 32'h0000_4411;
        e.weVec = (32'h1 << 14) | (32'h1 << 12) | (32'h1 << 13);
        e.wdata = slot(14, 32'h1000_0004) | slot(12, 32'h0000_FF03) | slot(13, 32'h0000_0010);
        bus.flush = 1'b1;
        applyStimulus(s, e);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        $display("[TB] asynchronous reset with two held entries");
        bus.out_ready = 1'b0;
        applyStimulus(gprStim(5'd6, 32'h6666_6666), gprExp(5'd6, 32'h6666_6666, 16'd1));
        applyStimulus(gprStim(5'd7, 32'h7777_7777), gprExp(5'd7, 32'h7777_7777, 16'd1));
        checkOutput("pre_reset_in_ready", bus.in_ready, 1'b0);
        #2;
        reset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("async_out_valid", bus.out_valid, 1'b0);
        checkOutput("async_in_ready",  bus.in_ready, 1'b1);
        checkOutput("async_strobes",   {bus.wb_wr_reg, bus.cp_we_vec, bus.cp_drop}, '0);
        checkOutput("async_cnt",       bus.cp_conflict_cnt, 16'h0000);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        applyStimulus(gprStim(5'd9, 32'h9999_0009), gprExp(5'd9, 32'h9999_0009, 16'd0));

        $display("[TB] saturating collision counter");
        checkOutput("sat_start_cnt", bus2.cp_conflict_cnt, 16'hFFFF);
        bus2.out_ready = 1'b1;
        bus2.in_cp_we = 1'b1;  bus2.in_cp_addr = 5'd14;  bus2.in_cp_data = 32'hAAAA_AAAA;
        bus2.in_exc_we = 4'b0001;  bus2.in_exc_data = {96'h0, 32'hBFC0_0380};
        bus2.in_valid = 1'b1;
        @(posedge clock); #1;
        bus2.in_valid = 1'b0;
        checkOutput("sat_we_vec", bus2.cp_we_vec, 32'h1 << 14);
        @(posedge clock); #1;
        checkOutput("sat_cnt", bus2.cp_conflict_cnt, 16'hFFFF);

        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
